// File: rtl/vga_clk_pkg.sv
// Shared types and constants for the DCM reset sequencer and its synchronisers.
// Optional macro DCM_STATUS_MON_EN (consumed by dcm_reset_sequencer) enables CLKFX/CLKIN stop monitoring.
package vga_clk_pkg;

  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Bit indices into the full 8-bit DCM_SP STATUS bus; the block only sees STATUS[2:1].
  localparam int STAT_CLKIN_STOP = 1;
  localparam int STAT_CLKFX_STOP = 2;

  localparam int DEF_RST_HOLD_CYCLES = 4;
  localparam int DEF_LOCK_TIMEOUT    = 120000;
  localparam int DEF_STABLE_CYCLES   = 1024;
  localparam int DEF_MAX_RETRIES     = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser for signals arriving asynchronously to clk.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Sequences DCM_SP reset/lock for the VGA pixel clock and releases the vga_clk-domain reset.
// Macro DCM_STATUS_MON_EN: also monitor DCM STATUS (CLKFX stopped / CLKIN stopped).
module dcm_reset_sequencer
  import vga_clk_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dcm_locked,
  input  logic [1:0] dcm_status,
  output logic       dcm_rst,
  output logic       clk_ok,
  output logic       sys_rst,
  output logic       fault,
  output logic [2:0] retry_count,
  output state_t     dbg_state
);

  localparam int CNT_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_HOLD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_retry;
  logic [2:0]       w_next_retry;
  logic             w_fail;
  logic             w_restart;
  logic             w_cnt_clr;
  logic             w_lock_s;
  logic             w_lock_ok;
  logic             w_clkin_stop;

  sync2 #(.W(1)) u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .i_d   (dcm_locked),
    .o_q   (w_lock_s)
  );

`ifdef DCM_STATUS_MON_EN
  logic [1:0] w_stat_s;

  sync2 #(.W(2)) u_sync_stat (
    .clk   (clk),
    .reset (reset),
    .i_d   (dcm_status),
    .o_q   (w_stat_s)
  );

  // LOCKED can stay high after CLKFX stops, so a stopped CLKFX counts as lost lock.
  assign w_lock_ok    = w_lock_s & ~w_stat_s[STAT_CLKFX_STOP-1];
  assign w_clkin_stop = w_stat_s[STAT_CLKIN_STOP-1];
`else
  logic w_unused_status;
  assign w_unused_status = ^dcm_status;
  assign w_lock_ok       = w_lock_s;
  assign w_clkin_stop    = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_retry = r_retry;
    w_fail       = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      RESET_DCM: if (r_cnt == CNT_W'(RST_HOLD_CYCLES - 1)) w_next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes priority over the timeout.
        if (w_lock_s) w_next_state = STABILIZE;
        else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) w_fail = 1'b1;
      end
      STABILIZE: begin
        if (!w_lock_ok) begin
          w_fail = 1'b1;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_next_state = RUN;
          w_next_retry = 3'd0;
        end
      end
      RUN:       if (!w_lock_ok) w_next_state = RESET_DCM;
      FAULT:     w_next_state = FAULT;
      default:   w_next_state = RESET_DCM;
    endcase

    if (w_fail) begin
      if (r_retry >= 3'(MAX_RETRIES)) begin
        w_next_state = FAULT;
      end else begin
        w_next_retry = r_retry + 3'd1;
        w_next_state = RESET_DCM;
      end
    end

    // A stopped input clock restarts the sequence without charging a retry.
    if (w_clkin_stop && r_state != FAULT) begin
      w_next_state = RESET_DCM;
      w_next_retry = r_retry;
      w_restart    = 1'b1;
    end
  end

  assign w_cnt_clr = (w_next_state != r_state) || w_restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_DCM;
      r_cnt   <= '0;
      r_retry <= 3'd0;
      dcm_rst <= 1'b1;
      clk_ok  <= 1'b0;
      sys_rst <= 1'b1;
      fault   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_cnt_clr)                  r_cnt <= '0;
      else if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      r_retry <= w_next_retry;
      // Outputs are registered from the next state so they line up with r_state.
      dcm_rst <= (w_next_state == RESET_DCM) || (w_next_state == FAULT);
      clk_ok  <= (w_next_state == RUN);
      sys_rst <= (w_next_state != RUN);
      fault   <= fault | (w_next_state == FAULT);
    end
  end

  assign retry_count = r_retry;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Bench for dcm_reset_sequencer: directed scenarios plus random LOCKED/STATUS traffic against a timeline model.
module tb_dcm_reset_sequencer;
  import vga_clk_pkg::*;

  localparam int RH = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_HOLD  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dcm_locked = 1'b0;
  logic [1:0] dcm_status = 2'b00;
  logic       dcm_rst;
  logic       clk_ok;
  logic       sys_rst;
  logic       fault;
  logic [2:0] retry_count;
  state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  int       m_phase;
  int       m_t;
  int       m_fails;
  bit       lk_q[$];
  bit [1:0] st_q[$];

  dcm_reset_sequencer #(
    .RST_HOLD_CYCLES (RH),
    .LOCK_TIMEOUT    (LT),
    .STABLE_CYCLES   (SC),
    .MAX_RETRIES     (MR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dcm_locked  (dcm_locked),
    .dcm_status  (dcm_status),
    .dcm_rst     (dcm_rst),
    .clk_ok      (clk_ok),
    .sys_rst     (sys_rst),
    .fault       (fault),
    .retry_count (retry_count),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fail();
    if (m_fails >= MR) begin
      m_phase = P_FAULT;
    end else begin
      m_fails++;
      m_phase = P_HOLD;
    end
    m_t = 0;
  endtask

  // Timeline model: each phase lasts a number of clk edges; decisions see inputs two edges late.
  task automatic model_step(input bit rst, input bit lk_in, input bit [1:0] st_in);
    bit       lk;
    bit [1:0] st;
    bit       good;
    if (rst) begin
      m_phase = P_HOLD;
      m_t     = 0;
      m_fails = 0;
      lk_q.delete();
      st_q.delete();
      lk_q.push_back(1'b0);
      lk_q.push_back(1'b0);
      st_q.push_back(2'b00);
      st_q.push_back(2'b00);
      return;
    end
    lk_q.push_back(lk_in);
    st_q.push_back(st_in);
    lk = lk_q.pop_front();
    st = st_q.pop_front();
    good = lk;
`ifdef DCM_STATUS_MON_EN
    if (st[0] && m_phase != P_FAULT) begin
      m_phase = P_HOLD;
      m_t     = 0;
      return;
    end
    good = lk && !st[1];
`endif
    case (m_phase)
      P_HOLD: if (m_t + 1 == RH) begin m_phase = P_WAIT; m_t = 0; end else m_t++;
      P_WAIT: begin
        if (lk) begin m_phase = P_STAB; m_t = 0; end
        else if (m_t + 1 == LT) model_fail();
        else m_t++;
      end
      P_STAB: begin
        if (!good) model_fail();
        else if (m_t + 1 == SC) begin m_phase = P_RUN; m_t = 0; m_fails = 0; end
        else m_t++;
      end
      P_RUN: if (!good) begin m_phase = P_HOLD; m_t = 0; end
      default: ;
    endcase
  endtask

  task automatic cycle(input bit rst, input bit lk, input bit [1:0] st);
    reset      = rst;
    dcm_locked = lk;
    dcm_status = st;
    model_step(rst, lk, st);
    @(posedge clk);
    @(negedge clk);
    check("dcm_rst", {7'd0, dcm_rst}, {7'd0, (m_phase == P_HOLD) || (m_phase == P_FAULT)});
    check("clk_ok", {7'd0, clk_ok}, {7'd0, m_phase == P_RUN});
    check("sys_rst", {7'd0, sys_rst}, {7'd0, m_phase != P_RUN});
    check("fault", {7'd0, fault}, {7'd0, m_phase == P_FAULT});
    check("retry_count", {5'd0, retry_count}, 8'(m_fails));
  endtask

  initial begin
    int       n_hi;
    int       first;
    bit       rlk;
    int       run;
    int       st_run;
    bit [1:0] st_v;
    bit       rst_v;

    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'b00);

    // Nominal lock: LOCKED rises 5 cycles after dcm_rst falls.
    n_hi = dcm_rst;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, 2'b00);
      n_hi += dcm_rst;
    end
    check("rst_pulse_len", 8'(n_hi), 8'd4);
    first = -1;
    for (int j = 0; j < 40; j++) begin
      cycle(1'b0, 1'b1, 2'b00);
      if (first < 0 && clk_ok) first = j;
    end
    check("lock_to_ok", 8'(first), 8'(2 + SC));
    check("nominal_retry", {5'd0, retry_count}, 8'd0);

    // Lock lost in RUN for 3 cycles.
    first = -1;
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 1'b0, 2'b00);
      if (first < 0 && !clk_ok) first = j;
    end
    check("drop_to_ok_low", 8'(first), 8'd2);
    for (int j = 0; j < 40; j++) cycle(1'b0, 1'b1, 2'b00);
    check("recover_ok", {7'd0, clk_ok}, 8'd1);
    check("recover_retry", {5'd0, retry_count}, 8'd0);

    // Lock never arrives: retries then FAULT.
    cycle(1'b1, 1'b0, 2'b00);
    for (int j = 0; j < 90; j++) cycle(1'b0, 1'b0, 2'b00);
    check("fault_set", {7'd0, fault}, 8'd1);
    check("fault_dcm_rst", {7'd0, dcm_rst}, 8'd1);
    check("fault_retry", {5'd0, retry_count}, 8'(MR));
    for (int j = 0; j < 10; j++) cycle(1'b0, 1'b1, 2'b00);
    check("fault_sticky", {7'd0, fault}, 8'd1);
    cycle(1'b1, 1'b0, 2'b00);
    check("fault_cleared", {7'd0, fault}, 8'd0);

    // Unstable lock: 5 locked cycles in STABILIZE then a one-cycle drop.
    for (int j = 0; j < 4; j++) cycle(1'b0, 1'b0, 2'b00);
    for (int j = 0; j < 6; j++) cycle(1'b0, 1'b1, 2'b00);
    cycle(1'b0, 1'b0, 2'b00);
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 2'b00);
    check("unstable_retry", {5'd0, retry_count}, 8'd1);
    check("unstable_no_ok", {7'd0, clk_ok}, 8'd0);

    // Reset while in STABILIZE.
    cycle(1'b1, 1'b0, 2'b00);
    for (int j = 0; j < 8; j++) cycle(1'b0, 1'b1, 2'b00);
    cycle(1'b1, 1'b1, 2'b00);
    check("midrst_dcm_rst", {7'd0, dcm_rst}, 8'd1);
    check("midrst_sys_rst", {7'd0, sys_rst}, 8'd1);
    check("midrst_retry", {5'd0, retry_count}, 8'd0);

    // CLKFX stopped while LOCKED stays high.
    for (int j = 0; j < 30; j++) cycle(1'b0, 1'b1, 2'b00);
    check("pre_status_ok", {7'd0, clk_ok}, 8'd1);
    for (int j = 0; j < 10; j++) cycle(1'b0, 1'b1, 2'b10);
`ifdef DCM_STATUS_MON_EN
    check("clkfx_stop_ok", {7'd0, clk_ok}, 8'd0);
`else
    check("clkfx_stop_ok", {7'd0, clk_ok}, 8'd1);
`endif

    // Random LOCKED runs with occasional STATUS events and resets.
    rlk = 1'b0;
    run = 0;
    st_run = 0;
    st_v = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      rst_v = ($urandom_range(0, 399) == 0);
      if (run == 0) begin
        rlk = !rlk;
        run = rlk ? $urandom_range(1, 60) : $urandom_range(1, 30);
      end
      run--;
      if (st_run == 0) begin
        st_v   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        st_run = $urandom_range(1, 8);
      end
      st_run--;
      cycle(rst_v, rlk, st_v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcm_reset_sequencer.md
Name: dcm_reset_sequencer

Overview:
Sequences the DCM_SP that synthesises the 25 MHz VGA pixel clock from the 12 MHz board clock. Pulses the DCM reset for the required hold time, waits for LOCKED with a timeout and retries, and requires lock to stay stable before release. Releases a downstream reset for the VGA timing and renderer logic. Detects loss of lock in operation, re-runs the sequence, and latches a fault after too many failed attempts.

Parameters:
RST_HOLD_CYCLES, 4, clk cycles dcm_rst is held high per attempt (DCM_SP needs at least 3 CLKIN cycles); must be at least 3.
LOCK_TIMEOUT, 120000, clk cycles to wait for lock per attempt (10 ms at 12 MHz).
STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before release.
MAX_RETRIES, 7, failed attempts allowed before FAULT; 1..7.

Ports:
clk  in  1  12 MHz board clock; same net as the DCM CLKIN.
reset  in  1  synchronous, active-high.
dcm_locked  in  1  DCM LOCKED; asynchronous to clk.
dcm_status  in  2  DCM STATUS[2:1]: bit1 = CLKFX stopped, bit0 = CLKIN stopped; asynchronous.
dcm_rst  out  1  drives DCM RST.
clk_ok  out  1  high only in RUN.
sys_rst  out  1  active-high reset for the vga_clk-domain logic; equals ~clk_ok.
fault  out  1  sticky; set on entry to FAULT.
retry_count  out  3  failed attempts since the last reset.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Input synchronisation: dcm_locked and dcm_status pass through 2-flop synchronisers (lock_s, stat_s). All decisions use synchronised values, adding 2 cycles of latency.
- Reset values: state=RESET_DCM, dcm_rst=1, clk_ok=0, sys_rst=1, fault=0, retry_count=0, counter=0.
- Counter: one shared counter, CNT_W = clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_HOLD_CYCLES)+1) bits. It is cleared on every state transition.
- RESET_DCM:
  - dcm_rst=1.
  - After RST_HOLD_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK:
  - dcm_rst=0.
  - If lock_s=1, go to STABILIZE.
  - If the counter reaches LOCK_TIMEOUT-1 without lock, it is a failed attempt: increment retry_count.
  - If retry_count+1 > MAX_RETRIES, go to FAULT; otherwise go to RESET_DCM.
  - Lock on the timeout cycle wins over timeout.
- STABILIZE:
  - dcm_rst=0.
  - If lock_s drops, treat as a failed attempt (same retry rule as WAIT_LOCK).
  - After STABLE_CYCLES consecutive lock_s=1 cycles, go to RUN.
- RUN:
  - clk_ok=1, sys_rst=0.
  - If lock_s drops, go to RESET_DCM. This does not increment retry_count; retry_count clears to 0 on entry to RUN.
  - clk_ok falls in the same cycle the drop is registered, so the drop reaches clk_ok 3 clk cycles after dcm_locked falls (2-cycle synchroniser plus one register).
- FAULT:
  - dcm_rst=1 (DCM held in reset), fault=1, clk_ok=0.
  - Only reset exits FAULT.
- Saturation: retry_count never exceeds MAX_RETRIES.
- Output timing: all outputs are registered; no combinational path from any input to any output.
- Reset mid-operation: reset asserted in any state returns to RESET_DCM with reset values on the next edge, including clearing fault.
- Glitches: a single-cycle LOCKED glitch that survives the synchroniser in STABILIZE counts as a failure. STABLE_CYCLES requires strictly consecutive lock.

Optional Feature:
Macro: DCM_STATUS_MON_EN.
- Defined: in STABILIZE or RUN, stat_s[1]=1 (CLKFX stopped) is treated exactly like lock_s dropping. This is needed because DCM_SP can keep LOCKED high while CLKFX has stopped. stat_s[0] (CLKIN stopped) in any state except FAULT forces RESET_DCM without counting a retry.
- Undefined: dcm_status is ignored (no synchroniser instantiated); only LOCKED is monitored.

Decomposition:
- Shared package vga_clk_pkg holds:
  - the state enum (RESET_DCM, WAIT_LOCK, STABILIZE, RUN, FAULT);
  - DCM status bit-index constants STAT_CLKIN_STOP=1, STAT_CLKFX_STOP=2 (indices into the full 8-bit STATUS);
  - default timing constants.
- One sub-module, sync2: a parameterised-width 2-flop synchroniser, instantiated for lock and for status.

Test Plan:
All scenarios use RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal lock: dcm_locked rises 5 cycles after dcm_rst falls and stays high -> dcm_rst high exactly 4 cycles; clk_ok/sys_rst toggle exactly 2 + 8 cycles after the registered lock; retry_count=0.
2. Lock timeout and retry: dcm_locked held low -> dcm_rst pulses 4 cycles every 24 cycles; retry_count goes 1, then 2; then FAULT with fault=1 and dcm_rst=1 held; reset then clears fault.
3. Lock lost in RUN: in RUN, dcm_locked low for 3 cycles -> clk_ok falls 3 cycles after the drop; new 4-cycle dcm_rst pulse; retry_count stays 0; recovers to RUN.
4. Unstable lock: lock high for 5 cycles in STABILIZE, low for 1 cycle -> back to RESET_DCM, retry_count=1, clk_ok never asserted.
5. Reset mid-sequence: assert reset during STABILIZE -> next edge gives dcm_rst=1, sys_rst=1, counter=0, retry_count=0.
6. With DCM_STATUS_MON_EN defined: in RUN, set dcm_status[1]=1 with dcm_locked still high -> clk_ok drops and RESET_DCM is entered; without the macro, clk_ok stays 1.
